// File: rtl/proc_sequencer.sv
// proc_sequencer: fetches 9-bit instruction words from an external program
// ROM and issues them to a processor using a Run/Done handshake. Words with
// opcode 001 (mvi) have their immediate fetched from the next address and
// presented on ProcDIN while the processor works on the instruction.
//
// Ports
//   Clock       single clock, all state changes on its rising edge
//   Reset       synchronous, active-high
//   Start       level; starts execution at address 0 from IDLE/HALT/ERR
//   StepMode    pause after every completed instruction
//   Step        rising edge releases one instruction from PAUSE
//   RomAddr     registered ROM address (data returns one cycle later)
//   RomData     ROM word
//   ProcDIN     registered processor data input
//   ProcRun     one-cycle Run strobe per issued instruction
//   ProcDone    processor Done, only observed while waiting
//   Busy        executing (F1, D1, F2, D2, RUN, WAIT, PAUSE)
//   Halted      halt opcode reached
//   Error       processor did not answer within TIMEOUT cycles
//   InstrCount  completed instructions, saturating at 255
module proc_sequencer #(
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned TIMEOUT = 8,
  parameter logic [2:0]  HALT_OP = 3'b111
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Start,
  input  logic              StepMode,
  input  logic              Step,
  output logic [ADDR_W-1:0] RomAddr,
  input  logic [8:0]        RomData,
  output logic [8:0]        ProcDIN,
  output logic              ProcRun,
  input  logic              ProcDone,
  output logic              Busy,
  output logic              Halted,
  output logic              Error,
  output logic [7:0]        InstrCount
);

  localparam logic [2:0] OP_MVI = 3'b001;
  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] T_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_F1, S_D1, S_F2, S_D2, S_RUN, S_WAIT, S_PAUSE, S_HALT, S_ERR
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [8:0]        ir;
  logic [8:0]        imm;
  logic [CW-1:0]     tcnt;
  logic              step_q;
  logic              step_rise;
  logic              is_mvi;
  logic [ADDR_W-1:0] pc_next;

  assign step_rise = Step & ~step_q;
  assign is_mvi    = (ir[8:6] == OP_MVI);
  assign pc_next   = is_mvi ? pc + ADDR_W'(2) : pc + ADDR_W'(1);

  // RomAddr is loaded on the edge that enters F1 (and again in F1), so the
  // ROM has sampled the right address by the time D1 captures its data.
  // Busy/Halted/Error/ProcRun are set on the transitions that enter the
  // corresponding states, keeping them registered.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state      <= S_IDLE;
      pc         <= '0;
      RomAddr    <= '0;
      ProcDIN    <= '0;
      ir         <= '0;
      imm        <= '0;
      ProcRun    <= 1'b0;
      Busy       <= 1'b0;
      Halted     <= 1'b0;
      Error      <= 1'b0;
      InstrCount <= '0;
      tcnt       <= '0;
      step_q     <= 1'b0;
    end else begin
      step_q  <= Step;
      ProcRun <= 1'b0;
      unique case (state)
        S_IDLE, S_HALT, S_ERR: begin
          if (Start) begin
            pc         <= '0;
            RomAddr    <= '0;
            InstrCount <= '0;
            Busy       <= 1'b1;
            Halted     <= 1'b0;
            Error      <= 1'b0;
            state      <= S_F1;
          end
        end
        S_F1: begin
          RomAddr <= pc;
          state   <= S_D1;
        end
        S_D1: begin
          ir <= RomData;
          if (RomData[8:6] == HALT_OP) begin
            Busy   <= 1'b0;
            Halted <= 1'b1;
            state  <= S_HALT;
          end else if (RomData[8:6] == OP_MVI) begin
            RomAddr <= pc + ADDR_W'(1);
            state   <= S_F2;
          end else begin
            ProcRun <= 1'b1;
            ProcDIN <= RomData;
            state   <= S_RUN;
          end
        end
        S_F2: state <= S_D2;
        S_D2: begin
          imm     <= RomData;
          ProcRun <= 1'b1;
          ProcDIN <= ir;
          state   <= S_RUN;
        end
        S_RUN: begin
          tcnt    <= '0;
          ProcDIN <= is_mvi ? imm : ir;
          state   <= S_WAIT;
        end
        S_WAIT: begin
          if (ProcDone) begin
            if (InstrCount != 8'hFF) InstrCount <= InstrCount + 8'd1;
            pc      <= pc_next;
            RomAddr <= pc_next;
            state   <= StepMode ? S_PAUSE : S_F1;
          end else if (tcnt == T_LAST) begin
            Busy  <= 1'b0;
            Error <= 1'b1;
            state <= S_ERR;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        S_PAUSE: begin
          if (!StepMode || step_rise) begin
            RomAddr <= pc;
            state   <= S_F1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_proc_sequencer.sv
// Bench for proc_sequencer: a synchronous ROM model, a processor model that
// answers Done one cycle after Run, a table of single-instruction programs,
// and directed sequences for stepping, timeout, PC wrap, count saturation
// and reset during WAIT.
module tb_proc_sequencer;

  localparam logic [8:0] HALT_W = 9'h1C0;

  logic       clk = 1'b0;
  logic       Reset, Start, StepMode, Step;
  logic [4:0] RomAddr;
  logic [8:0] RomData;
  logic [8:0] ProcDIN;
  logic       ProcRun, ProcDone;
  logic       Busy, Halted, Error;
  logic [7:0] InstrCount;

  logic [8:0] rom [32];
  logic       done_q     = 1'b0;
  logic       auto_done  = 1'b1;
  logic       done_force = 1'b0;

  int errors = 0;
  int checks = 0;

  proc_sequencer #(.ADDR_W(5), .TIMEOUT(8), .HALT_OP(3'b111)) dut (
    .Clock(clk), .Reset(Reset), .Start(Start), .StepMode(StepMode),
    .Step(Step), .RomAddr(RomAddr), .RomData(RomData), .ProcDIN(ProcDIN),
    .ProcRun(ProcRun), .ProcDone(ProcDone), .Busy(Busy), .Halted(Halted),
    .Error(Error), .InstrCount(InstrCount)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) RomData <= rom[RomAddr];
  always @(posedge clk) done_q <= auto_done & ProcRun;
  assign ProcDone = done_q | done_force;

  typedef struct {
    logic [8:0] w0;
    logic [8:0] w1;
    int         lat;
    int         pulses;
    logic [8:0] din_run;
    logic [8:0] din_wait;
    logic [4:0] end_addr;
    logic [7:0] cnt;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fill_rom(input logic [8:0] w);
    for (int unsigned i = 0; i < 32; i++) rom[i] = w;
  endtask

  task automatic run_vec(input vec_t v);
    int n, pulses, lat;
    logic [8:0] drun, dwait;
    logic prev;
    fill_rom(HALT_W);
    rom[0] = v.w0;
    rom[1] = v.w1;
    Start = 1'b1;
    n = 0; pulses = 0; lat = 0; prev = 1'b0; drun = '0; dwait = '0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) Start = 1'b0;
      if (ProcRun) begin
        pulses++;
        if (pulses == 1) begin
          lat  = n;
          drun = ProcDIN;
        end
      end
      if (prev) dwait = ProcDIN;
      prev = ProcRun;
    end while (!Halted && n < 25);
    chk("vec_halted", Halted, 1);
    chk("vec_pulses", pulses, v.pulses);
    if (v.pulses > 0) begin
      chk("vec_latency", lat, v.lat);
      chk("vec_din_run", drun, v.din_run);
      chk("vec_din_wait", dwait, v.din_wait);
    end
    chk("vec_romaddr", RomAddr, v.end_addr);
    chk("vec_count", InstrCount, v.cnt);
    chk("vec_busy", Busy, 0);
  endtask

  initial begin
    int n, m, cnt;
    logic found;

    vecs[0] = '{9'h00A, HALT_W, 3, 1, 9'h00A, 9'h00A, 5'd1, 8'd1};
    vecs[1] = '{9'h058, 9'h0A5, 5, 1, 9'h058, 9'h0A5, 5'd2, 8'd1};
    vecs[2] = '{9'h081, HALT_W, 3, 1, 9'h081, 9'h081, 5'd1, 8'd1};
    vecs[3] = '{9'h04F, 9'h1FF, 5, 1, 9'h04F, 9'h1FF, 5'd2, 8'd1};
    vecs[4] = '{HALT_W, HALT_W, 0, 0, 9'h000, 9'h000, 5'd0, 8'd0};
    vecs[5] = '{9'h1B5, HALT_W, 3, 1, 9'h1B5, 9'h1B5, 5'd1, 8'd1};

    fill_rom(HALT_W);
    Reset = 1'b1; Start = 1'b0; StepMode = 1'b0; Step = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_romaddr", RomAddr, 0);
    chk("rst_procdin", ProcDIN, 0);
    chk("rst_procrun", ProcRun, 0);
    chk("rst_flags", {Busy, Halted, Error}, 0);
    chk("rst_count", InstrCount, 0);
    Reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Step mode: one instruction per Step rising edge, held Step counts once
    fill_rom(HALT_W);
    rom[0] = 9'h00A; rom[1] = 9'h011; rom[2] = 9'h012;
    StepMode = 1'b1;
    Start = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      Start = 1'b0;
    end while (InstrCount != 8'd1 && n < 20);
    cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (ProcRun) cnt++;
    end
    chk("pause_no_run", cnt, 0);
    chk("pause_count", InstrCount, 1);
    chk("pause_busy", Busy, 1);
    Step = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (ProcRun) cnt++;
    end
    Step = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (ProcRun) cnt++;
    end
    chk("step_pulses", cnt, 1);
    chk("step_count", InstrCount, 2);
    chk("step_busy", Busy, 1);
    chk("step_romaddr", RomAddr, 2);
    StepMode = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!Halted && n < 20);
    chk("resume_halted", Halted, 1);
    chk("resume_count", InstrCount, 3);

    // Timeout: no Done -> ERR after exactly 8 WAIT cycles
    fill_rom(HALT_W);
    rom[0] = 9'h00A;
    auto_done = 1'b0;
    Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    n = 0;
    while (!ProcRun && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("to_run_seen", ProcRun, 1);
    m = 0;
    do begin
      @(negedge clk);
      m++;
    end while (!Error && m < 20);
    chk("to_cycles", m, 9);
    chk("to_busy", Busy, 0);
    chk("to_count", InstrCount, 0);
    chk("to_procdin_hold", ProcDIN, 9'h00A);

    // Restart from ERR; Done in the last allowed WAIT cycle completes
    Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    chk("restart_error", Error, 0);
    chk("restart_romaddr", RomAddr, 0);
    n = 0;
    while (!ProcRun && n < 10) begin
      @(negedge clk);
      n++;
    end
    repeat (8) @(negedge clk);
    done_force = 1'b1;
    @(negedge clk);
    done_force = 1'b0;
    chk("last_done_error", Error, 0);
    chk("last_done_count", InstrCount, 1);
    auto_done = 1'b1;
    n = 0;
    while (!Halted && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("last_done_halted", Halted, 1);

    // PC wrap: mvi at address 31 takes immediate from address 0
    rom[0] = 9'h0C3;
    for (int unsigned i = 1; i < 31; i++) rom[i] = {3'b000, 6'(i)};
    rom[31] = 9'h058;
    Start = 1'b1;
    n = 0;
    found = 1'b0;
    while (!found && n < 400) begin
      @(negedge clk);
      n++;
      Start = 1'b0;
      if (ProcRun && ProcDIN == 9'h058) found = 1'b1;
    end
    chk("wrap_found", found, 1);
    chk("wrap_count_before", InstrCount, 31);
    chk("wrap_imm_addr", RomAddr, 0);
    @(negedge clk);
    chk("wrap_imm", ProcDIN, 9'h0C3);
    @(negedge clk);
    chk("wrap_next_fetch", RomAddr, 1);
    chk("wrap_count_after", InstrCount, 32);

    // Saturation: keep running until far beyond 255 completions
    cnt = 0;
    n = 0;
    while (cnt < 240 && n < 2000) begin
      @(negedge clk);
      n++;
      if (ProcRun) cnt++;
    end
    chk("sat_runs", cnt, 240);
    chk("sat_count", InstrCount, 8'hFF);

    // Reset during WAIT with Done asserted
    @(negedge clk);
    Reset = 1'b1;
    done_force = 1'b1;
    @(negedge clk);
    Reset = 1'b0;
    done_force = 1'b0;
    chk("wrst_romaddr", RomAddr, 0);
    chk("wrst_procdin", ProcDIN, 0);
    chk("wrst_procrun", ProcRun, 0);
    chk("wrst_flags", {Busy, Halted, Error}, 0);
    chk("wrst_count", InstrCount, 0);

    // Done outside WAIT is ignored
    done_force = 1'b1;
    repeat (3) @(negedge clk);
    done_force = 1'b0;
    chk("idle_done_count", InstrCount, 0);
    chk("idle_busy", Busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
